cbb_row_accumulator: RTL and testbench

Collect-and-Buffer Block (CBB) row accumulator, directly downstream of the If-Mul Units. It takes the 4-lane partial-product rows produced by an IMU (value × DDM row, or all-zero for a zero value) and sums them lane-wise into one output row. The number of partial products per row comes from the NNZ/row predictor. When that count is reached, it presents the finished row to the output buffer with a valid/ready handshake.

---
 rtl/cbb_row_accumulator_pkg.sv | 12 +
 rtl/cbb_lane_adder.sv | 13 +
 rtl/cbb_row_accumulator.sv | 68 ++++++
 tb/tb_cbb_row_accumulator.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/cbb_row_accumulator_pkg.sv
// cbb_row_accumulator_pkg: widths and FSM encodings shared by the CBB, IMU, DSMU and RSMU
package cbb_row_accumulator_pkg;
  localparam int BIT_WIDTH = 32;
  localparam int TILE_WIDTH = 4;
  localparam int NNZ_WIDTH = 4;
  localparam int ROW_IDX_WIDTH = 8;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/cbb_lane_adder.sv
// cbb_lane_adder: lane-wise wrapping adder with no carry between lanes
module cbb_lane_adder #(
  parameter int BIT_WIDTH = cbb_row_accumulator_pkg::BIT_WIDTH,
  parameter int TILE_WIDTH = cbb_row_accumulator_pkg::TILE_WIDTH
) (
  input  logic [BIT_WIDTH*TILE_WIDTH-1:0] a,
  input  logic [BIT_WIDTH*TILE_WIDTH-1:0] b,
  output logic [BIT_WIDTH*TILE_WIDTH-1:0] sum
);
  for (genvar g = 0; g < TILE_WIDTH; g++) begin : g_lane
    assign sum[g*BIT_WIDTH +: BIT_WIDTH] = a[g*BIT_WIDTH +: BIT_WIDTH] + b[g*BIT_WIDTH +: BIT_WIDTH];
  end
endmodule

// File: rtl/cbb_row_accumulator.sv
// cbb_row_accumulator: sums a counted run of IMU partial-product rows and hands the row to the output buffer
module cbb_row_accumulator #(
  parameter int BIT_WIDTH = cbb_row_accumulator_pkg::BIT_WIDTH,
  parameter int TILE_WIDTH = cbb_row_accumulator_pkg::TILE_WIDTH,
  parameter int NNZ_WIDTH = cbb_row_accumulator_pkg::NNZ_WIDTH,
  parameter int ROW_IDX_WIDTH = cbb_row_accumulator_pkg::ROW_IDX_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [NNZ_WIDTH-1:0]            nnz_count,
  input  logic [ROW_IDX_WIDTH-1:0]        row_idx,
  input  logic                            in_valid,
  input  logic [BIT_WIDTH*TILE_WIDTH-1:0] in_data,
  output logic                            in_ready,
  output logic                            out_valid,
  output logic [BIT_WIDTH*TILE_WIDTH-1:0] out_data,
  output logic [ROW_IDX_WIDTH-1:0]        out_row_idx,
  input  logic                            out_ready,
  output logic                            busy
);
  import cbb_row_accumulator_pkg::*;
  state_t state, state_nxt;
  logic [NNZ_WIDTH-1:0] remaining;
  logic [BIT_WIDTH*TILE_WIDTH-1:0] acc, sum;
  logic accept, load;
  assign in_ready = state == ACCUM;
  assign out_valid = state == DRAIN;
  assign busy = state != IDLE;
  assign out_data = acc;
  assign accept = in_valid && in_ready;
  assign load = state == IDLE && start;
  cbb_lane_adder #(.BIT_WIDTH(BIT_WIDTH), .TILE_WIDTH(TILE_WIDTH)) u_add (
    .a(acc),
    .b(in_data),
    .sum(sum)
  );
  // next state: a zero-length row skips straight to DRAIN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? (nnz_count == '0 ? DRAIN : ACCUM) : IDLE;
      ACCUM:   state_nxt = accept && remaining == NNZ_WIDTH'(1) ? DRAIN : ACCUM;
      DRAIN:   state_nxt = out_ready ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  // row setup on start, lane-wise accumulation on each accepted product
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      remaining <= '0;
      out_row_idx <= '0;
    end else if (load) begin
      acc <= '0;
      remaining <= nnz_count;
      out_row_idx <= row_idx;
    end else if (accept) begin
      acc <= sum;
      remaining <= remaining - NNZ_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_cbb_row_accumulator.sv
// tb_cbb_row_accumulator: directed checks of accumulation, wrap, zero-length rows, backpressure and reset
module tb_cbb_row_accumulator;
  logic clk = 0;
  logic rst, start, in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0] nnz_count;
  logic [7:0] row_idx, out_row_idx;
  logic [127:0] in_data, out_data;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  cbb_row_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .nnz_count(nnz_count), .row_idx(row_idx),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_row_idx(out_row_idx), .out_ready(out_ready), .busy(busy)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(0));
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_out_data"}, out_data, 128'(0));
    chk({tag, "_row_idx"}, 128'(out_row_idx), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
  endtask
  initial begin
    rst = 1; start = 0; nnz_count = 0; row_idx = 0; in_valid = 0; in_data = 0; out_ready = 0;
    tick(); tick();
    rst = 0;
    chk_reset("reset");
    // single product
    start = 1; nnz_count = 1; row_idx = 5;
    tick();
    start = 0;
    chk("single_busy", 128'(busy), 128'(1));
    chk("single_in_ready", 128'(in_ready), 128'(1));
    chk("single_no_valid", 128'(out_valid), 128'(0));
    in_valid = 1; in_data = {32'd4, 32'd3, 32'd2, 32'd1};
    tick();
    in_valid = 0;
    chk("single_out_valid", 128'(out_valid), 128'(1));
    chk("single_out_data", out_data, {32'd4, 32'd3, 32'd2, 32'd1});
    chk("single_row_idx", 128'(out_row_idx), 128'(5));
    chk("single_in_ready_drain", 128'(in_ready), 128'(0));
    out_ready = 1;
    tick();
    chk("single_idle", 128'(busy), 128'(0));
    chk("single_valid_drop", 128'(out_valid), 128'(0));
    // three back to back with out_ready high
    start = 1; nnz_count = 3; row_idx = 7;
    tick();
    start = 0; in_valid = 1; in_data = {32'd1, 32'd1, 32'd1, 32'd1};
    tick();
    in_data = {32'd2, 32'd0, 32'd2, 32'd0};
    tick();
    chk("three_not_done", 128'(out_valid), 128'(0));
    in_data = '0;
    tick();
    in_valid = 0;
    chk("three_out_valid", 128'(out_valid), 128'(1));
    chk("three_out_data", out_data, {32'd3, 32'd1, 32'd3, 32'd1});
    chk("three_row_idx", 128'(out_row_idx), 128'(7));
    tick();
    chk("three_idle", 128'(busy), 128'(0));
    // wrap in lane 0, then backpressure
    out_ready = 0;
    start = 1; nnz_count = 2; row_idx = 9;
    tick();
    start = 0; in_valid = 1; in_data = {32'd10, 32'd20, 32'd30, 32'hFFFF_FFFF};
    tick();
    in_data = {32'd0, 32'd0, 32'd0, 32'd2};
    tick();
    in_valid = 0;
    chk("wrap_out_valid", 128'(out_valid), 128'(1));
    chk("wrap_out_data", out_data, {32'd10, 32'd20, 32'd30, 32'd1});
    for (int i = 0; i < 4; i++) begin
      in_valid = i[0]; in_data = {32'd1, 32'd1, 32'd1, 32'd1};
      tick();
      chk("bp_out_data", out_data, {32'd10, 32'd20, 32'd30, 32'd1});
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_row_idx", 128'(out_row_idx), 128'(9));
    end
    in_valid = 0; out_ready = 1;
    tick();
    chk("bp_idle", 128'(busy), 128'(0));
    chk("bp_valid_drop", 128'(out_valid), 128'(0));
    // zero-length row
    start = 1; nnz_count = 0; row_idx = 3;
    tick();
    start = 0;
    chk("zero_out_valid", 128'(out_valid), 128'(1));
    chk("zero_out_data", out_data, 128'(0));
    chk("zero_row_idx", 128'(out_row_idx), 128'(3));
    chk("zero_in_ready", 128'(in_ready), 128'(0));
    tick();
    chk("zero_idle", 128'(busy), 128'(0));
    // start during ACCUM is ignored
    out_ready = 0;
    start = 1; nnz_count = 2; row_idx = 4;
    tick();
    nnz_count = 0; row_idx = 8; in_valid = 1; in_data = {32'd1, 32'd1, 32'd1, 32'd1};
    tick();
    start = 0;
    chk("ign_no_valid", 128'(out_valid), 128'(0));
    chk("ign_row_idx", 128'(out_row_idx), 128'(4));
    tick();
    in_valid = 0;
    chk("ign_out_valid", 128'(out_valid), 128'(1));
    chk("ign_out_data", out_data, {32'd2, 32'd2, 32'd2, 32'd2});
    out_ready = 1;
    tick();
    out_ready = 0;
    // reset mid-row after 2 of 4 products
    start = 1; nnz_count = 4; row_idx = 11;
    tick();
    start = 0; in_valid = 1; in_data = {32'd1, 32'd2, 32'd3, 32'd4};
    tick(); tick();
    in_valid = 0; rst = 1;
    tick();
    rst = 0;
    chk_reset("midrst");
    start = 1; nnz_count = 1; row_idx = 2;
    tick();
    start = 0; in_valid = 1; in_data = {32'd5, 32'd5, 32'd5, 32'd5};
    tick();
    in_valid = 0;
    chk("fresh_out_valid", 128'(out_valid), 128'(1));
    chk("fresh_out_data", out_data, {32'd5, 32'd5, 32'd5, 32'd5});
    chk("fresh_row_idx", 128'(out_row_idx), 128'(2));
    out_ready = 1;
    tick();
    chk("fresh_idle", 128'(busy), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
